fetch_unit_mips: RTL and testbench
==================================

# fetch_unit_mips

Instruction-fetch stage of the MIPS-based soft processor. Holds the program counter, drives the word address into `instruction_memory_mips` (combinational read), captures the returned instruction into the IF/ID pipeline register, and handles stall, branch/jump redirect with flush, halt, and out-of-range fault. It sits directly upstream of instruction memory and feeds the decode stage.

## Interface
- `n_bit`, 31, MSB index of address/instruction buses (width = n_bit+1).
- `memory_size`, 2047, highest valid word address of instruction memory.
- `reset_addr`, 0, PC value after reset.

- `in_clk`  input  1  rising-edge clock.
- `in_reset`  input  1  synchronous, active-high reset.
- `in_stall`  input  1  hold PC and IF/ID (hazard from decode).
- `in_branch_taken`  input  1  redirect to `in_branch_target`.
- `in_branch_target`  input  n_bit+1  branch word address.
- `in_jump`  input  1  redirect to `in_jump_target`.
- `in_jump_target`  input  n_bit+1  jump word address.
- `in_halt`  input  1  decode saw halt; stop fetching.
- `in_instruction`  input  n_bit+1  from memory `out_instruction`.
- `out_addr`  output  n_bit+1  PC; to memory `in_addr`.
- `out_if_id_instruction`  output  n_bit+1  registered instruction.
- `out_if_id_pc_plus1`  output  n_bit+1  registered address of next sequential word.
- `out_if_id_valid`  output  1  IF/ID holds a real instruction.
- `out_halted`  output  1  FSM in HALTED.
- `out_fault`  output  1  sticky: redirect target > memory_size.

## Operation
- Word-addressed: sequential next PC = PC+1; PC == memory_size wraps to 0.
- FSM states: RUN, HALTED. Reset -> RUN.
- RUN, per edge, priority high to low:
  1. `in_branch_taken`: PC <= branch target; IF/ID flushed (instruction = NOP 32'h0, valid = 0).
  2. `in_jump`: same with jump target.
  3. `in_halt`: -> HALTED; IF/ID flushed; PC holds.
  4. `in_stall`: PC and IF/ID hold.
  5. else: IF/ID <= {in_instruction, PC+1 (wrapped), valid=1}; PC <= next sequential.
- Redirect overrides stall in the same cycle. Branch wins over jump when both are set.
- Redirect target > memory_size: PC not updated, IF/ID flushed, `out_fault` <= 1, -> HALTED.
- HALTED: PC, IF/ID frozen with valid = 0; all inputs except reset ignored; only reset exits.
- `out_halted` = (state == HALTED).

## Timing
- Reset values: `out_addr` = reset_addr, IF/ID instruction = 0, pc_plus1 = 0, valid = 0, `out_halted` = 0, `out_fault` = 0, state RUN.
- Reset mid-operation wins over every other input on that edge.
- `out_addr` is a register; memory answers in the same cycle; instruction is visible on `out_if_id_instruction` one edge later (fetch latency 1).
- First edge with reset low: IF/ID <= mem[reset_addr], valid = 1.
- Redirect penalty: exactly one bubble (valid = 0) cycle, then target instruction.
- All outputs registered except `out_halted` (decoded from the state register).

## Structure
- Shared package `mips_fetch_pkg`: NOP constant (32'h0), FSM state encoding (RUN, HALTED), default reset_addr.
- One sub-module is natural: `pc_register_mips` (PC register, next-PC mux, wrap and range check); the IF/ID register and FSM stay in `fetch_unit_mips`.

## Test plan
- Reset, then 5 free-running cycles, memory mem[i] = i+32'h100: `out_addr` 0,1,2,3,4,5; IF/ID 0x100..0x104, pc_plus1 1..5, valid 1 from first post-reset edge.
- Stall high 2 cycles at PC = 3: `out_addr` stays 3, IF/ID holds 0x102; resumes with 0x103.
- Branch to 10 at PC = 4 with stall also high: next `out_addr` = 10, one valid = 0 cycle, then IF/ID = 0x10A, pc_plus1 = 11; repeat with branch+jump (jump target 20) together -> PC = 10.
- Sequential run reaching PC = memory_size (2047): next `out_addr` = 0, IF/ID pc_plus1 = 0.
- Jump to 3000: `out_fault` = 1, `out_halted` = 1, PC unchanged, valid = 0, further stimulus ignored; reset clears both flags and PC = 0.
- `in_halt` at PC = 6: halted, PC frozen at 6, valid = 0 for 5 cycles; assert reset mid-halt -> all reset values next edge.

Source files
------------

// File: rtl/fetch_unit_mips_pkg.sv
// mips_fetch_pkg: constants and types shared by the instruction-fetch stage.
//   NOP                - instruction loaded into IF/ID on a flush
//   fetch_state_e      - fetch FSM encoding (RUN, HALTED)
//   DEFAULT_RESET_ADDR - PC value after reset unless overridden
package mips_fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int DEFAULT_RESET_ADDR = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_mips_if.sv
// fetch_unit_mips_if: control and data bundle between the fetch stage and its
// neighbours (decode supplies stall/redirect/halt, instruction memory supplies
// the instruction word; fetch returns the PC and the IF/ID register contents).
//   slave  - view taken by fetch_unit_mips
//   master - view taken by the surrounding pipeline / testbench
interface fetch_unit_mips_if #(
    parameter int n_bit = 31
);
    logic             in_stall;
    logic             in_branch_taken;
    logic [n_bit:0]   in_branch_target;
    logic             in_jump;
    logic [n_bit:0]   in_jump_target;
    logic             in_halt;
    logic [n_bit:0]   in_instruction;
    logic [n_bit:0]   out_addr;
    logic [n_bit:0]   out_if_id_instruction;
    logic [n_bit:0]   out_if_id_pc_plus1;
    logic             out_if_id_valid;
    logic             out_halted;
    logic             out_fault;

    modport slave (
        input  in_stall, in_branch_taken, in_branch_target, in_jump,
               in_jump_target, in_halt, in_instruction,
        output out_addr, out_if_id_instruction, out_if_id_pc_plus1,
               out_if_id_valid, out_halted, out_fault
    );

    modport master (
        output in_stall, in_branch_taken, in_branch_target, in_jump,
               in_jump_target, in_halt, in_instruction,
        input  out_addr, out_if_id_instruction, out_if_id_pc_plus1,
               out_if_id_valid, out_halted, out_fault
    );
endinterface

// File: rtl/fetch_unit_mips_pc_register.sv
// pc_register_mips: program counter with next-PC selection.
//   clk_i, rst_i    - clock, synchronous active-high reset
//   advance_i       - step to the next sequential word
//   redirect_i      - load target_i (only honoured when target is in range)
//   target_i        - redirect word address
//   pc_o            - current PC
//   pc_plus1_o      - next sequential word address, wrapped at memory_size
//   target_bad_o    - target_i lies beyond the last instruction word
module pc_register_mips
    import mips_fetch_pkg::*;
#(
    parameter int n_bit       = 31,
    parameter int memory_size = 2047,
    parameter int reset_addr  = DEFAULT_RESET_ADDR
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           advance_i,
    input  logic           redirect_i,
    input  logic [n_bit:0] target_i,
    output logic [n_bit:0] pc_o,
    output logic [n_bit:0] pc_plus1_o,
    output logic           target_bad_o
);
    localparam logic [n_bit:0] MEM_LAST   = (n_bit+1)'(memory_size);
    localparam logic [n_bit:0] RESET_ADDR = (n_bit+1)'(reset_addr);

    logic [n_bit:0] pc_q;
    logic [n_bit:0] pc_d;

    assign pc_plus1_o   = (pc_q == MEM_LAST) ? '0 : pc_q + 1'b1;
    assign target_bad_o = (target_i > MEM_LAST);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i && !target_bad_o) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_plus1_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit_mips.sv
// fetch_unit_mips: MIPS instruction-fetch stage.
//   in_clk, in_reset - clock, synchronous active-high reset
//   bus (slave)      - stall/branch/jump/halt from decode, instruction from
//                      memory; PC, IF/ID register, halted and fault flags out
//
// state  | meaning
// RUN    | fetching; redirect > halt > stall > sequential fetch
// HALTED | PC and IF/ID frozen (valid = 0); only reset leaves
module fetch_unit_mips
    import mips_fetch_pkg::*;
#(
    parameter int n_bit       = 31,
    parameter int memory_size = 2047,
    parameter int reset_addr  = DEFAULT_RESET_ADDR
) (
    input  logic              in_clk,
    input  logic              in_reset,
    fetch_unit_mips_if.slave  bus
);
    fetch_state_e   state_q, state_d;
    logic [n_bit:0] instr_q, instr_d;
    logic [n_bit:0] pc1_q, pc1_d;
    logic           valid_q, valid_d;
    logic           fault_q, fault_d;

    logic           redirect;
    logic [n_bit:0] target;
    logic           target_bad;
    logic           advance;
    logic           redirect_ok;
    logic [n_bit:0] pc;
    logic [n_bit:0] pc_plus1;

    assign redirect = bus.in_branch_taken | bus.in_jump;
    // Branch has priority over jump when both are presented together.
    assign target   = bus.in_branch_taken ? bus.in_branch_target : bus.in_jump_target;

    pc_register_mips #(
        .n_bit       (n_bit),
        .memory_size (memory_size),
        .reset_addr  (reset_addr)
    ) u_pc (
        .clk_i        (in_clk),
        .rst_i        (in_reset),
        .advance_i    (advance),
        .redirect_i   (redirect_ok),
        .target_i     (target),
        .pc_o         (pc),
        .pc_plus1_o   (pc_plus1),
        .target_bad_o (target_bad)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc1_d       = pc1_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        advance     = 1'b0;
        redirect_ok = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    instr_d = (n_bit+1)'(NOP);
                    valid_d = 1'b0;
                    if (target_bad) begin
                        // Out-of-range target: keep PC, latch fault, stop.
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        redirect_ok = 1'b1;
                    end
                end else if (bus.in_halt) begin
                    instr_d = (n_bit+1)'(NOP);
                    valid_d = 1'b0;
                    state_d = HALTED;
                end else if (!bus.in_stall) begin
                    instr_d = bus.in_instruction;
                    pc1_d   = pc_plus1;
                    valid_d = 1'b1;
                    advance = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= RUN;
            instr_q <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign bus.out_addr              = pc;
    assign bus.out_if_id_instruction = instr_q;
    assign bus.out_if_id_pc_plus1    = pc1_q;
    assign bus.out_if_id_valid       = valid_q;
    assign bus.out_fault             = fault_q;
    assign bus.out_halted            = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_unit_mips.sv
// Directed testbench for fetch_unit_mips. Instruction memory is modelled as
// mem[i] = i + 32'h100. Each step pushes the expected post-edge outputs onto
// a scoreboard queue, clocks once, then pops and compares.
module tb_fetch_unit_mips;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc1;
        logic        valid;
        logic        halted;
        logic        fault;
        bit          chk_pc1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    fetch_unit_mips_if #(.n_bit(31)) dut_if ();

    fetch_unit_mips #(
        .n_bit       (31),
        .memory_size (2047),
        .reset_addr  (0)
    ) dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (dut_if.slave)
    );

    always #5 clk = ~clk;

    assign dut_if.in_instruction = dut_if.out_addr + 32'h100;

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got=%0h exp=%0h", tag, fld, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] a,
                        input logic [31:0] i, input logic [31:0] p,
                        input logic v, input logic h, input logic f,
                        input bit chk_p);
        exp_t e;
        e.tag = tag; e.addr = a; e.instr = i; e.pc1 = p;
        e.valid = v; e.halted = h; e.fault = f; e.chk_pc1 = chk_p;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "addr",   dut_if.out_addr,              e.addr);
        chk(e.tag, "instr",  dut_if.out_if_id_instruction, e.instr);
        if (e.chk_pc1) chk(e.tag, "pc1", dut_if.out_if_id_pc_plus1, e.pc1);
        chk(e.tag, "valid",  {31'b0, dut_if.out_if_id_valid}, {31'b0, e.valid});
        chk(e.tag, "halted", {31'b0, dut_if.out_halted},      {31'b0, e.halted});
        chk(e.tag, "fault",  {31'b0, dut_if.out_fault},       {31'b0, e.fault});
    endtask

    task automatic idle_inputs();
        dut_if.in_stall         = 1'b0;
        dut_if.in_branch_taken  = 1'b0;
        dut_if.in_branch_target = '0;
        dut_if.in_jump          = 1'b0;
        dut_if.in_jump_target   = '0;
        dut_if.in_halt          = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;

        // reset values
        step("reset", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        // free run: fetch latency 1, valid from first post-reset edge
        for (int k = 1; k <= 5; k++)
            step("run", k, 32'h100 + k - 1, k, 1, 0, 0, 1);

        // re-reset and run up to PC = 3
        rst = 1'b1;
        step("reset2", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++)
            step("run2", k, 32'h100 + k - 1, k, 1, 0, 0, 1);

        // stall two cycles at PC = 3
        dut_if.in_stall = 1'b1;
        step("stall1", 3, 32'h102, 3, 1, 0, 0, 1);
        step("stall2", 3, 32'h102, 3, 1, 0, 0, 1);
        dut_if.in_stall = 1'b0;
        step("resume", 4, 32'h103, 4, 1, 0, 0, 1);

        // branch to 10 at PC = 4 with stall also high: redirect wins
        dut_if.in_stall         = 1'b1;
        dut_if.in_branch_taken  = 1'b1;
        dut_if.in_branch_target = 32'd10;
        step("br_bubble", 10, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        step("br_target", 11, 32'h10A, 11, 1, 0, 0, 1);

        // branch + jump together: branch wins
        dut_if.in_branch_taken  = 1'b1;
        dut_if.in_branch_target = 32'd10;
        dut_if.in_jump          = 1'b1;
        dut_if.in_jump_target   = 32'd20;
        step("brj_bubble", 10, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        step("brj_target", 11, 32'h10A, 11, 1, 0, 0, 1);

        // wrap at memory_size
        dut_if.in_jump        = 1'b1;
        dut_if.in_jump_target = 32'd2045;
        step("jmp_2045", 2045, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        step("wrap_a", 2046, 32'h100 + 2045, 2046, 1, 0, 0, 1);
        step("wrap_b", 2047, 32'h100 + 2046, 2047, 1, 0, 0, 1);
        step("wrap_c", 0,    32'h100 + 2047, 0,    1, 0, 0, 1);
        step("wrap_d", 1,    32'h100,        1,    1, 0, 0, 1);

        // out-of-range jump: fault, halted, PC unchanged
        dut_if.in_jump        = 1'b1;
        dut_if.in_jump_target = 32'd3000;
        step("fault", 1, 0, 0, 0, 1, 1, 0);
        idle_inputs();
        dut_if.in_branch_taken  = 1'b1;
        dut_if.in_branch_target = 32'd5;
        step("fault_ign1", 1, 0, 0, 0, 1, 1, 0);
        idle_inputs();
        step("fault_ign2", 1, 0, 0, 0, 1, 1, 0);
        dut_if.in_halt = 1'b1;
        step("fault_ign3", 1, 0, 0, 0, 1, 1, 0);
        idle_inputs();
        rst = 1'b1;
        step("fault_rst", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        // halt at PC = 6
        for (int k = 1; k <= 6; k++)
            step("run3", k, 32'h100 + k - 1, k, 1, 0, 0, 1);
        dut_if.in_halt = 1'b1;
        step("halt", 6, 0, 0, 0, 1, 0, 0);
        dut_if.in_halt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dut_if.in_stall       = k[0];
            dut_if.in_jump        = 1'b1;
            dut_if.in_jump_target = 32'd7;
            step("halt_hold", 6, 0, 0, 0, 1, 0, 0);
        end
        // reset wins over every other input on the same edge
        dut_if.in_branch_taken  = 1'b1;
        dut_if.in_branch_target = 32'd9;
        rst = 1'b1;
        step("halt_rst", 0, 0, 0, 0, 0, 0, 1);
        idle_inputs();
        rst = 1'b0;
        step("post_rst", 1, 32'h100, 1, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
